huffman_stream_dec: RTL and testbench
=====================================

# huffman_stream_dec

Parametrised streaming canonical-Huffman decoder. It accepts packed code bits in IN_W-bit words over a valid/ready handshake and decodes one bit per cycle against a runtime-loadable canonical table (per-length counts plus symbol list). Decoded symbols leave on a second valid/ready handshake. Compared with the fixed 8-bit decoder it adds programmable tables, codes that span word boundaries, backpressure, and invalid-code detection. It sits between the compressed-stream source and the symbol consumer in the Huffman datapath.

## Interface
- IN_W, 8: input word width; bits are consumed MSB first.
- SYM_W, 8: symbol width.
- MAX_LEN, 8: maximum code length, 1..15.
- NSYM, 2**SYM_W: symbol table depth.
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state, counters and tables.
- in_valid / in_ready  in / out  1  input word handshake.
- in_data  in  IN_W  packed code bits.
- out_valid / out_ready  out / in  1  symbol handshake.
- out_sym  out  SYM_W  decoded symbol.
- err  out  1  one-cycle pulse on an invalid code.
- busy  out  1  decode in progress (partial code or unconsumed bits).
- cnt_we, cnt_addr[$clog2(MAX_LEN+1)], cnt_data[$clog2(NSYM+1)]  in  count-table write for code length cnt_addr (1..MAX_LEN).
- sym_we, sym_addr[$clog2(NSYM)], sym_data[SYM_W]  in  symbol-table write (canonical order).

## Operation
- **FSM states:** FETCH, DECODE, EMIT. The state resets to FETCH.
- **in_ready** is 1 only in FETCH. An accepted word loads the shift register with bit counter = IN_W, then the FSM goes to DECODE.
- **DECODE, one bit per cycle:**
  - code = code | bit; len += 1; c = cnt[len].
  - Match when code >= first and (code − first) < c. On a match, latch out_sym = sym[index + code − first], clear code/first/index/len, and go to EMIT.
  - Otherwise: index += c; first = (first + c) << 1; code <<= 1.
- **Widths:** code/first/index are MAX_LEN+1 bits unsigned. Arithmetic on them is modulo that width, with no saturation.
- **Invalid code:** if no match occurs when len reaches MAX_LEN, pulse err for one cycle and clear the code state. Decoding continues with the next bit; no symbol is emitted.
- **EMIT:**
  - out_valid = 1, and out_sym is held stable until out_ready.
  - On handshake: go to DECODE if bits remain, else FETCH.
- **Words exhausted mid-code:** code/first/index/len are retained across FETCH, so codes span word boundaries.
- **Table writes:** accepted only when busy = 0; writes while busy = 1 are dropped. The new value is visible from the next cycle. Simultaneous cnt_we and sym_we are both honoured.
- **busy** = (state != FETCH) or (len != 0).

## Timing
- **Reset values:** out_valid 0, out_sym 0, err 0, busy 0, in_ready 1 after reset deasserts, all table entries 0.
- **Latency:** word accepted in cycle 0 → bits processed in cycles 1..L → out_valid in cycle L+1 for an L-bit code starting the word.
- **Throughput:** each symbol costs L decode cycles plus ≥1 EMIT cycle.
- **Input bubble:** last bit consumed → FETCH the next cycle; in_ready is asserted that cycle.
- **err** is asserted the cycle after the MAX_LEN-th bit is processed.
- **Reset mid-operation:** the partial code and the pending symbol are discarded; out_valid drops asynchronously.

## Structure
- **huffman_pkg:** state enum dec_state_t (FETCH, DECODE, EMIT) and shared width helper localparams. The existing verification interface imports it.
- **Sub-module huffman_bit_unpacker:** shift register plus bit counter, with the in_valid/in_ready handshake and a `take_bit` strobe.
- **Top level:** FSM, canonical arithmetic and both table memories.

## Test plan
All scenarios use this table: cnt[1]=1, cnt[2]=1, cnt[3]=2; sym[0..3]=0x41, 0x42, 0x43, 0x44 (codes 0, 10, 110, 111).

- **Cross-word decode:** send 0x5B, then 0x80 with out_ready=1 → symbols 0x41, 0x42, 0x43, 0x44, then seven 0x41.
- **Latency:** send 0x00 after idle → first out_valid exactly 2 cycles after acceptance.
- **Backpressure:** out_ready=0 for 5 cycles during EMIT → out_valid and out_sym are stable, in_ready=0, and no symbol is lost.
- **Invalid code:** clear all counts, send 0x00 → err pulses once, 9 cycles after acceptance; no out_valid.
- **Dropped config write:** issue a sym_we to address 0 while busy=1 → still decodes 0x41.
- **Reset mid-operation:** assert reset mid-code after 0xC0 → after release, busy=0 and out_valid=0; a fresh 0x00 yields 0x41.

Source files
------------

// File: rtl/huffman_pkg.sv
// huffman_pkg: decoder state encoding and shared width helpers for the
// Huffman stream decoder and its verification interface.
package huffman_pkg;
  typedef enum logic [1:0] {FETCH, DECODE, EMIT} dec_state_t;
  localparam int DEF_IN_W = 8;
  localparam int DEF_SYM_W = 8;
  localparam int DEF_MAX_LEN = 8;
  function automatic int code_w(input int max_len);
    return max_len + 1;
  endfunction
endpackage

// File: rtl/huffman_stream_dec_if.sv
// huffman_stream_dec_if: input word stream, symbol stream, status and table-write
// signals of the Huffman stream decoder.
interface huffman_stream_dec_if import huffman_pkg::*; #(
  parameter int IN_W = DEF_IN_W,
  parameter int SYM_W = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int NSYM = 2**SYM_W
);
  localparam int CA_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(NSYM + 1);
  localparam int SA_W = $clog2(NSYM);
  logic in_valid, in_ready, out_valid, out_ready, err, busy, cnt_we, sym_we;
  logic [IN_W-1:0] in_data;
  logic [SYM_W-1:0] out_sym, sym_data;
  logic [CA_W-1:0] cnt_addr;
  logic [CNT_W-1:0] cnt_data;
  logic [SA_W-1:0] sym_addr;
  modport master (
    output in_valid, in_data, out_ready, cnt_we, cnt_addr, cnt_data, sym_we, sym_addr, sym_data,
    input in_ready, out_valid, out_sym, err, busy
  );
  modport slave (
    input in_valid, in_data, out_ready, cnt_we, cnt_addr, cnt_data, sym_we, sym_addr, sym_data,
    output in_ready, out_valid, out_sym, err, busy
  );
endinterface

// File: rtl/huffman_bit_unpacker.sv
// huffman_bit_unpacker: holds one input word and presents its bits MSB first,
// one per take_bit strobe; accepts a new word only while the decoder fetches.
module huffman_bit_unpacker #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  input  logic            take_bit,
  output logic            in_ready,
  output logic            cur_bit,
  output logic            last,
  output logic            empty
);
  localparam int BC_W = $clog2(IN_W + 1);
  logic [IN_W-1:0] sr;
  logic [BC_W-1:0] bc;
  assign in_ready = fetch;
  assign cur_bit = sr[IN_W-1];
  assign last = bc == BC_W'(1);
  assign empty = bc == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr <= '0;
      bc <= '0;
    end else if (in_valid && in_ready) begin
      sr <= in_data;
      bc <= BC_W'(IN_W);
    end else if (take_bit) begin
      sr <= sr << 1;
      bc <= bc - 1'b1;
    end
endmodule

// File: rtl/huffman_stream_dec.sv
// huffman_stream_dec: streaming canonical-Huffman decoder, one code bit per cycle
// against runtime-loaded per-length counts and a canonical-order symbol table.
module huffman_stream_dec import huffman_pkg::*; #(
  parameter int IN_W = DEF_IN_W,
  parameter int SYM_W = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int NSYM = 2**SYM_W
) (
  input logic clk,
  input logic reset,
  huffman_stream_dec_if.slave bus
);
  localparam int CW = code_w(MAX_LEN);
  localparam int CA_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(NSYM + 1);
  localparam int SA_W = $clog2(NSYM);
  dec_state_t state, state_n;
  logic [CNT_W-1:0] cnt [MAX_LEN+1];
  logic [SYM_W-1:0] sym [NSYM];
  logic [CW-1:0] code, first, index, code_b, c, off;
  logic [CA_W-1:0] len, len_b;
  logic [SYM_W-1:0] out_sym;
  logic take_bit, cur_bit, last, empty, hit, give_up, busy, err;
  huffman_bit_unpacker #(.IN_W(IN_W)) u_unpack (
    .clk(clk), .reset(reset), .fetch(state == FETCH), .in_valid(bus.in_valid),
    .in_data(bus.in_data), .take_bit(take_bit), .in_ready(bus.in_ready),
    .cur_bit(cur_bit), .last(last), .empty(empty)
  );
  assign busy = state != FETCH || len != '0;
  assign bus.busy = busy;
  assign bus.out_valid = state == EMIT;
  assign bus.out_sym = out_sym;
  assign bus.err = err;
  always_comb begin
    code_b = code | CW'(cur_bit);
    len_b = len + 1'b1;
    c = CW'(cnt[len_b]);
    off = code_b - first;
    hit = code_b >= first && off < c;
    give_up = !hit && len_b == CA_W'(MAX_LEN);
    take_bit = state == DECODE;
    state_n = state;
    case (state)
      FETCH:   state_n = bus.in_valid ? DECODE : FETCH;
      DECODE:  state_n = hit ? EMIT : (last ? FETCH : DECODE);
      default: state_n = !bus.out_ready ? EMIT : (empty ? FETCH : DECODE);
    endcase
  end
  // Code state survives FETCH so a code may straddle input words.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FETCH;
      code <= '0;
      first <= '0;
      index <= '0;
      len <= '0;
      out_sym <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      err <= take_bit && give_up;
      if (take_bit) begin
        if (hit || give_up) begin
          code <= '0;
          first <= '0;
          index <= '0;
          len <= '0;
        end else begin
          code <= code_b << 1;
          first <= (first + c) << 1;
          index <= index + c;
          len <= len_b;
        end
        if (hit) out_sym <= sym[SA_W'(index + off)];
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i <= MAX_LEN; i++) cnt[i] <= '0;
      for (int i = 0; i < NSYM; i++) sym[i] <= '0;
    end else if (!busy) begin
      if (bus.cnt_we && bus.cnt_addr <= CA_W'(MAX_LEN)) cnt[bus.cnt_addr] <= bus.cnt_data;
      if (bus.sym_we) sym[bus.sym_addr] <= bus.sym_data;
    end
endmodule

// File: tb/tb_huffman_stream_dec.sv
// tb_huffman_stream_dec: scenario tasks for the Huffman stream decoder with a
// symbol scoreboard filled at stimulus time and drained on output handshakes.
module tb_huffman_stream_dec;
  import huffman_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  huffman_stream_dec_if bus();
  huffman_stream_dec dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_sym;
  always @(negedge clk) begin
    if (!reset && bus.err) err_seen++;
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got symbol %h, expected none", bus.out_sym);
      end else begin
        exp_sym = exp_q.pop_front();
        if (bus.out_sym !== exp_sym) begin
          errors++;
          $display("FAIL sb_sym: got %h, expected %h", bus.out_sym, exp_sym);
        end
      end
    end
  end
  task automatic push_n(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask
  task automatic cfg_cnt(input int a, input int d);
    bus.cnt_we = 1'b1;
    bus.cnt_addr = a[3:0];
    bus.cnt_data = d[8:0];
    @(posedge clk); #1;
    bus.cnt_we = 1'b0;
  endtask
  task automatic cfg_sym(input int a, input int d);
    bus.sym_we = 1'b1;
    bus.sym_addr = a[7:0];
    bus.sym_data = d[7:0];
    @(posedge clk); #1;
    bus.sym_we = 1'b0;
  endtask
  task automatic load_table(input int c1, input int c2, input int c3, input bit syms);
    cfg_cnt(1, c1);
    cfg_cnt(2, c2);
    cfg_cnt(3, c3);
    if (syms) for (int i = 0; i < 4; i++) cfg_sym(i, 'h41 + i);
  endtask
  task automatic send_word(input logic [7:0] d);
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready, t);
    end
    bus.in_valid = 1'b1;
    bus.in_data = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy || bus.out_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL %s_drain: %0d symbols outstanding busy=%b, expected 0 and 0", name, exp_q.size(), bus.busy);
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_sym !== 8'h00) begin errors++; $display("FAIL rst_out_sym: got %h, expected 00", bus.out_sym); end
    if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, expected 0", bus.err); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask
  task automatic test_cross_word();
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h44);
    push_n(8'h41, 7);
    send_word(8'h5B);
    send_word(8'h80);
    wait_idle("cross_word");
  endtask
  task automatic test_latency();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept: in_ready=%b, expected 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1: out_valid=%b, expected 0", bus.out_valid); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sym !== 8'h41) begin
      errors++;
      $display("FAIL lat_cycle2: out_valid=%b sym=%h, expected 1 and 41", bus.out_valid, bus.out_sym);
    end
    push_n(8'h41, 8);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle("latency");
  endtask
  task automatic test_backpressure();
    int t = 0;
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h41);
    send_word(8'h5B);
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sym !== 8'h41 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b sym=%h in_ready=%b, expected 1 41 0", i, bus.out_valid, bus.out_sym, bus.in_ready);
      end
    end
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h43);
    push_n(8'h41, 4);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_word(8'hE0);
    wait_idle("backpressure");
  endtask
  task automatic test_dropped_write();
    bus.out_ready = 1'b1;
    push_n(8'h41, 8);
    send_word(8'h00);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b, expected 1", bus.busy); end
    cfg_sym(0, 'h99);
    wait_idle("dropped_write");
  endtask
  task automatic test_invalid();
    int first_err = 0;
    bit saw_valid = 1'b0;
    load_table(0, 0, 0, 1'b0);
    bus.out_ready = 1'b1;
    err_seen = 0;
    send_word(8'h00);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.err && first_err == 0) first_err = k;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    checks += 3;
    if (first_err != 9) begin errors++; $display("FAIL inv_err_cycle: got %0d, expected 9", first_err); end
    if (err_seen != 1) begin errors++; $display("FAIL inv_err_count: got %0d, expected 1", err_seen); end
    if (saw_valid) begin errors++; $display("FAIL inv_no_valid: got out_valid=1, expected 0"); end
    @(posedge clk); #1;
    load_table(1, 1, 2, 1'b0);
  endtask
  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send_word(8'hC0);
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_pre_busy: got %b, expected 1", bus.busy); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: busy=%b out_valid=%b, expected 0 0", bus.busy, bus.out_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_after: busy=%b out_valid=%b in_ready=%b, expected 0 0 1", bus.busy, bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    err_seen = 0;
    send_word(8'h00);
    repeat (12) @(negedge clk);
    checks++;
    if (err_seen != 1) begin errors++; $display("FAIL rm_tables_cleared: err count %0d, expected 1", err_seen); end
    @(posedge clk); #1;
    load_table(1, 1, 2, 1'b1);
    push_n(8'h41, 8);
    send_word(8'h00);
    wait_idle("reset_mid");
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus.cnt_we = 1'b0;
    bus.cnt_addr = '0;
    bus.cnt_data = '0;
    bus.sym_we = 1'b0;
    bus.sym_addr = '0;
    bus.sym_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    load_table(1, 1, 2, 1'b1);
    test_cross_word();
    test_latency();
    test_backpressure();
    test_dropped_write();
    test_invalid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
